pipe_ctrl_tracker: RTL and testbench

- Consumer end of the decoded control bundle produced in ID.
- Carries control signals and register indices through the ID/EX, EX/MEM and MEM/WB stage registers of the 5-stage RISC-V core.
- Generates the load-use stall, the branch/jump flush and the EX-stage forwarding selects.
- Keeps saturating stall and flush event counters.
- Sits between ID decode and the datapath pipeline registers.

---
 rtl/pipe_ctrl_tracker.sv | 125 ++++++++++++
 tb/tb_pipe_ctrl_tracker.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_tracker.sv
// pipe_ctrl_tracker: ID/EX, EX/MEM, MEM/WB control pipeline with hazard, forwarding and event counters
module pipe_ctrl_tracker #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            id_alu_op,
    input  logic                  id_alu_src,
    input  logic                  id_branch,
    input  logic                  id_jump,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_mem_2_reg,
    input  logic                  id_reg_write,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  branch_taken,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_flush,
    output logic [1:0]            ex_alu_op,
    output logic                  ex_alu_src,
    output logic                  ex_branch,
    output logic                  ex_jump,
    output logic [REG_ADDR_W-1:0] ex_rs1,
    output logic [REG_ADDR_W-1:0] ex_rs2,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  mem_mem_read,
    output logic                  mem_mem_write,
    output logic                  mem_mem_2_reg,
    output logic                  mem_reg_write,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  wb_mem_2_reg,
    output logic                  wb_reg_write,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);
    logic w_flush, w_stall, w_bubble;
    logic r_ex_mem_read, r_ex_mem_write, r_ex_mem_2_reg, r_ex_reg_write;

    assign w_flush     = ex_jump | (ex_branch & branch_taken);
    assign w_stall     = r_ex_mem_read & (ex_rd != '0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    assign w_bubble    = w_stall | w_flush;
    assign if_flush    = w_flush;
    assign pc_write    = ~w_stall | w_flush;
    assign if_id_write = ~w_stall | w_flush;

    // EX operand selects: the younger EX/MEM result wins over MEM/WB; x0 never forwards
    always_comb begin
        forward_a = (mem_reg_write && mem_rd != '0 && mem_rd == ex_rs1) ? 2'b10 :
                    (wb_reg_write && wb_rd != '0 && wb_rd == ex_rs1)    ? 2'b01 : 2'b00;
        forward_b = (mem_reg_write && mem_rd != '0 && mem_rd == ex_rs2) ? 2'b10 :
                    (wb_reg_write && wb_rd != '0 && wb_rd == ex_rs2)    ? 2'b01 : 2'b00;
    end

    // ID/EX register: a stall or flush inserts an all-zero bubble
    always_ff @(posedge clk) begin
        if (rst || w_bubble) begin
            ex_alu_op      <= '0;
            ex_alu_src     <= 1'b0;
            ex_branch      <= 1'b0;
            ex_jump        <= 1'b0;
            r_ex_mem_read  <= 1'b0;
            r_ex_mem_write <= 1'b0;
            r_ex_mem_2_reg <= 1'b0;
            r_ex_reg_write <= 1'b0;
            ex_rs1         <= '0;
            ex_rs2         <= '0;
            ex_rd          <= '0;
        end else begin
            ex_alu_op      <= id_alu_op;
            ex_alu_src     <= id_alu_src;
            ex_branch      <= id_branch;
            ex_jump        <= id_jump;
            r_ex_mem_read  <= id_mem_read;
            r_ex_mem_write <= id_mem_write;
            r_ex_mem_2_reg <= id_mem_2_reg;
            r_ex_reg_write <= id_reg_write;
            ex_rs1         <= id_rs1;
            ex_rs2         <= id_rs2;
            ex_rd          <= id_rd;
        end
    end

    // EX/MEM and MEM/WB registers advance every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_mem_read  <= 1'b0;
            mem_mem_write <= 1'b0;
            mem_mem_2_reg <= 1'b0;
            mem_reg_write <= 1'b0;
            mem_rd        <= '0;
            wb_mem_2_reg  <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_rd         <= '0;
        end else begin
            mem_mem_read  <= r_ex_mem_read;
            mem_mem_write <= r_ex_mem_write;
            mem_mem_2_reg <= r_ex_mem_2_reg;
            mem_reg_write <= r_ex_reg_write;
            mem_rd        <= ex_rd;
            wb_mem_2_reg  <= mem_mem_2_reg;
            wb_reg_write  <= mem_reg_write;
            wb_rd         <= mem_rd;
        end
    end

    // Saturating event counters; a stall hidden by a flush is not counted as a stall
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (w_stall && !w_flush && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (w_flush && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipe_ctrl_tracker.sv
// tb_pipe_ctrl_tracker: directed vector bench for the control pipeline tracker
module tb_pipe_ctrl_tracker;
    localparam int RW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    id_alu_op;
    logic          id_alu_src, id_branch, id_jump, id_mem_read, id_mem_write, id_mem_2_reg, id_reg_write;
    logic [RW-1:0] id_rs1, id_rs2, id_rd;
    logic          branch_taken;
    logic          pc_write, if_id_write, if_flush;
    logic [1:0]    ex_alu_op;
    logic          ex_alu_src, ex_branch, ex_jump;
    logic [RW-1:0] ex_rs1, ex_rs2, ex_rd;
    logic          mem_mem_read, mem_mem_write, mem_mem_2_reg, mem_reg_write;
    logic [RW-1:0] mem_rd;
    logic          wb_mem_2_reg, wb_reg_write;
    logic [RW-1:0] wb_rd;
    logic [1:0]    forward_a, forward_b;
    logic [CW-1:0] stall_cnt, flush_cnt;

    typedef struct {
        int op, src, br, jmp, mr, mw, m2r, rw, rs1, rs2, rd, bt;
        int pcw, ifl, fa, fb, exrd, memrd, wbrd, exc, memc, wbc, sc, fc;
    } vec_t;

    vec_t v[22];
    vec_t z;
    int   checks = 0;
    int   errors = 0;
    int   step = -1;

    always #5 clk = ~clk;

    pipe_ctrl_tracker #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_branch(id_branch), .id_jump(id_jump),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_2_reg(id_mem_2_reg),
        .id_reg_write(id_reg_write), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .branch_taken(branch_taken), .pc_write(pc_write), .if_id_write(if_id_write), .if_flush(if_flush),
        .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch), .ex_jump(ex_jump),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write), .mem_mem_2_reg(mem_mem_2_reg),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
        .wb_mem_2_reg(wb_mem_2_reg), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .forward_a(forward_a), .forward_b(forward_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, step, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        id_alu_op    = 2'(x.op);
        id_alu_src   = 1'(x.src);
        id_branch    = 1'(x.br);
        id_jump      = 1'(x.jmp);
        id_mem_read  = 1'(x.mr);
        id_mem_write = 1'(x.mw);
        id_mem_2_reg = 1'(x.m2r);
        id_reg_write = 1'(x.rw);
        id_rs1       = 5'(x.rs1);
        id_rs2       = 5'(x.rs2);
        id_rd        = 5'(x.rd);
        branch_taken = 1'(x.bt);
    endtask

    function automatic int exc_now();
        return int'({ex_alu_op, ex_alu_src, ex_branch, ex_jump});
    endfunction

    function automatic int memc_now();
        return int'({mem_mem_read, mem_mem_write, mem_mem_2_reg, mem_reg_write});
    endfunction

    function automatic int wbc_now();
        return int'({wb_mem_2_reg, wb_reg_write});
    endfunction

    initial begin
        z = '{default: 0};
        //        op src br jmp mr mw m2r rw rs1 rs2 rd bt | pcw ifl fa fb exrd memrd wbrd exc memc wbc sc fc
        v[0]  = '{0, 1, 0, 0, 1, 0, 1, 1, 2, 0, 5, 0,   1, 0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 0};
        v[1]  = '{2, 0, 0, 0, 0, 0, 0, 1, 5, 6, 7, 0,   0, 0, 0, 0, 5, 0, 0,  4,  0, 0, 0, 0};
        v[2]  = '{2, 0, 0, 0, 0, 0, 0, 1, 5, 6, 7, 0,   1, 0, 0, 0, 0, 5, 0,  0, 11, 0, 1, 0};
        v[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 7, 0, 5, 16,  0, 3, 1, 0};
        v[4]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 7, 0,   1, 0, 0, 0, 0, 7, 0,  0,  1, 0, 1, 0};
        v[5]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 7, 0,   1, 0, 0, 0, 7, 0, 7,  0,  0, 1, 1, 0};
        v[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 7, 7, 8, 0,   1, 0, 0, 0, 7, 7, 0,  0,  1, 0, 1, 0};
        v[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 7, 7, 9, 0,   1, 0, 2, 2, 8, 7, 7,  0,  1, 1, 1, 0};
        v[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 1, 1, 9, 8, 7,  0,  0, 1, 1, 0};
        v[9]  = '{0, 1, 0, 0, 1, 0, 1, 1, 3, 0, 0, 0,   1, 0, 0, 0, 0, 9, 8,  0,  0, 0, 1, 0};
        v[10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4, 0,   1, 0, 0, 0, 0, 0, 9,  4,  0, 0, 1, 0};
        v[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 4, 0, 0,  0, 11, 0, 1, 0};
        v[12] = '{0, 0, 1, 0, 1, 0, 0, 0, 1, 2, 5, 0,   1, 0, 0, 0, 0, 4, 0,  0,  1, 3, 1, 0};
        v[13] = '{0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 6, 1,   1, 1, 0, 0, 5, 0, 4,  2,  0, 1, 1, 0};
        v[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 5, 0,  0,  8, 0, 1, 1};
        v[15] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 3, 0,   1, 0, 0, 0, 0, 0, 5,  0,  0, 0, 1, 1};
        v[16] = '{0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 1, 0,   1, 1, 0, 0, 3, 0, 0,  1,  0, 0, 1, 1};
        v[17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 3, 0,  0,  1, 0, 1, 2};
        v[18] = '{0, 1, 0, 0, 1, 0, 1, 1, 0, 0, 9, 0,   1, 0, 0, 0, 0, 0, 3,  0,  0, 1, 1, 2};
        v[19] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 9, 2, 0,   0, 0, 0, 0, 9, 0, 0,  4,  0, 0, 1, 2};
        v[20] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 9, 2, 0,   1, 0, 0, 0, 0, 9, 0,  0, 11, 0, 2, 2};
        v[21] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 2, 0, 9,  0,  0, 3, 2, 2};

        drive(z);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            step = i;
            drive(v[i]);
            #1;
            chk("pc_write", int'(pc_write), v[i].pcw);
            chk("if_id_write", int'(if_id_write), v[i].pcw);
            chk("if_flush", int'(if_flush), v[i].ifl);
            chk("forward_a", int'(forward_a), v[i].fa);
            chk("forward_b", int'(forward_b), v[i].fb);
            chk("ex_rd", int'(ex_rd), v[i].exrd);
            chk("mem_rd", int'(mem_rd), v[i].memrd);
            chk("wb_rd", int'(wb_rd), v[i].wbrd);
            chk("ex_ctl", exc_now(), v[i].exc);
            chk("mem_ctl", memc_now(), v[i].memc);
            chk("wb_ctl", wbc_now(), v[i].wbc);
            chk("stall_cnt", int'(stall_cnt), v[i].sc);
            chk("flush_cnt", int'(flush_cnt), v[i].fc);
        end

        // reset arriving in the same cycle as a load-use stall
        step = 100;
        @(negedge clk);
        drive('{0, 1, 0, 0, 1, 0, 1, 1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        @(negedge clk);
        drive('{2, 0, 0, 0, 0, 0, 0, 1, 5, 0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        #1;
        chk("pre_reset_stall", int'(pc_write), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step = 101;
        #1;
        chk("rst_pc_write", int'(pc_write), 1);
        chk("rst_if_flush", int'(if_flush), 0);
        chk("rst_ex_rd", int'(ex_rd), 0);
        chk("rst_ex_rs1", int'(ex_rs1), 0);
        chk("rst_ex_ctl", exc_now(), 0);
        chk("rst_mem_rd", int'(mem_rd), 0);
        chk("rst_mem_ctl", memc_now(), 0);
        chk("rst_wb_rd", int'(wb_rd), 0);
        chk("rst_wb_ctl", wbc_now(), 0);
        chk("rst_stall_cnt", int'(stall_cnt), 0);
        chk("rst_flush_cnt", int'(flush_cnt), 0);

        // a jump in ID every cycle flushes on alternate cycles; counter must stop at 15
        step = 200;
        drive('{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        repeat (28) @(posedge clk);
        @(negedge clk);
        chk("flush_cnt_14", int'(flush_cnt), 14);
        step = 201;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("flush_cnt_15", int'(flush_cnt), 15);
        step = 202;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("flush_cnt_sat", int'(flush_cnt), 15);
        chk("stall_cnt_idle", int'(stall_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
